vga_line_fetch: RTL and testbench
=================================

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter H_DISP, default 640, active pixels per line; H_DISP SHALL be a multiple of BURST_LEN.
REQ-002 SHALL have parameter V_DISP, default 480, active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, words per memory burst.
REQ-004 SHALL have parameter ADDR_W, default 19, memory word-address width.
REQ-005 SHALL have parameter FB_BASE, default 0, frame-buffer base word address.
REQ-006 SHALL use one clock and a synchronous, active-low reset, with these ports:
- vga_clk  in  1  pixel clock, all logic on rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle pulse at the first cycle of vertical sync.
- data_req  in  1  high one cycle ahead of each displayed pixel.
- pixel_data  out  12  RGB444 pixel for the display driver.
- mem_req  out  1  burst request.
- mem_addr  out  ADDR_W  burst start address.
- mem_ack  in  1  burst grant, one cycle.
- mem_rvalid  in  1  read word valid.
- mem_rdata  in  12  read word.
- underflow  out  1  sticky flag: a line was displayed from an unfilled buffer.
- underflow_cnt  out  16  count of underflowed lines.

Function
REQ-007 SHALL hold two internal line buffers (ping-pong), each H_DISP x 12 bits, each with a valid flag; disp_sel selects the display buffer.
REQ-008 Fetch FSM SHALL have states IDLE, REQ, BURST.
- IDLE->REQ when a buffer other than the one being displayed is not valid and fetch_line < V_DISP.
- REQ->BURST on mem_ack.
- BURST->REQ after BURST_LEN mem_rvalid words, if the line is incomplete.
- BURST->IDLE when the line is complete; the target buffer's valid flag is set in the same cycle.
REQ-009 mem_addr SHALL equal FB_BASE + fetch_line*H_DISP + col, truncated to ADDR_W bits; col is the word offset of the burst.
REQ-010 mem_req SHALL assert in REQ, stay high until mem_ack, and keep mem_addr stable meanwhile.
REQ-011 Each mem_rvalid word SHALL be written to the target buffer at incrementing col; mem_rvalid outside BURST SHALL be ignored.
REQ-012 Fill order SHALL be: line 0 to buffer 0, line 1 to buffer 1, then each freed buffer gets the next line. No fetch SHALL start once fetch_line = V_DISP.
REQ-013 Display read address rd_x SHALL increment on every data_req cycle.
REQ-014 pixel_data SHALL be registered with 1-cycle latency from data_req: buffer[disp_sel][rd_x] if that buffer is valid, else the underflow value; it SHALL be 0 when data_req was low.
REQ-015 On the falling edge of data_req (line end), the block SHALL in one cycle clear valid[disp_sel], toggle disp_sel, and zero rd_x.
REQ-016 On a data_req rising edge with valid[disp_sel]=0, the block SHALL set underflow and increment underflow_cnt once per line, saturating at 16'hFFFF.
REQ-017 frame_start SHALL latch a restart request that is applied in IDLE, in REQ before mem_ack (mem_req drops the next cycle), or at the end of the current burst.
REQ-018 A restart SHALL clear both valid flags and set disp_sel=0, rd_x=0, fetch_line=0 and col=0. It SHALL NOT clear underflow or underflow_cnt.
REQ-019 A line-end swap coinciding with the completing fetch write SHALL apply both: the valid set is to the target buffer, the valid clear is to the display buffer, and they are distinct.

Reset
REQ-020 With sys_rst_n=0 at a clock edge, the block SHALL set:
- FSM to IDLE
- mem_req=0, mem_addr=0, pixel_data=0, underflow=0, underflow_cnt=0
- valid flags=0, disp_sel=0, rd_x=0, fetch_line=0
REQ-021 A reset during BURST SHALL abandon the burst; later mem_rvalid words SHALL be ignored.

Configuration
REQ-022 With macro VGA_LINE_FETCH_UNDERFLOW_MARK_EN defined, the underflow pixel value SHALL be 12'hF00 and underflow_cnt SHALL count per REQ-016.
REQ-023 Without the macro, the underflow pixel value SHALL be 12'h000 and underflow_cnt SHALL be held at 0; underflow SHALL still operate.

Verification (bench params H_DISP=32, V_DISP=4, BURST_LEN=8, FB_BASE=100)
REQ-024 Reset then frame_start, mem_ack one cycle after each mem_req, rdata=address -> four bursts at 100,108,116,124 fill buffer 0, then 132..156 fill buffer 1.
REQ-025 Lines 0-3 displayed with data_req 32 cycles high, 16 low -> pixel_data sequence 100..227 with 1-cycle latency, underflow=0.
REQ-026 mem_ack withheld until after the line-1 data_req rise -> underflow=1, line 1 pixels 12'hF00 with macro (12'h000 without), underflow_cnt=1 with macro (0 without).
REQ-027 frame_start mid-BURST at word 3 -> remaining 5 words accepted, then next mem_addr=100; no underflow clear.
REQ-028 sys_rst_n=0 for one cycle during BURST -> next cycle mem_req=0 and pixel_data=0; stray mem_rvalid ignored; the next frame_start restarts at address 100.

Source files
------------

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong line buffer between a burst-read frame buffer and a
// VGA display driver. A three-state fetch FSM fills whichever buffer the display
// is not using. The display side reads the current buffer one pixel per data_req
// and swaps buffers at each line end.
//
// Build option: define VGA_LINE_FETCH_UNDERFLOW_MARK_EN to show underflowed lines
// as red (12'hF00) and to count them in underflow_cnt. Without it, underflowed
// pixels are black and underflow_cnt stays at zero. The sticky underflow flag
// works in both builds.
//
// H_DISP must be a multiple of BURST_LEN, and ADDR_W must be 64 or less.
module vga_line_fetch #(
  parameter int unsigned H_DISP    = 640,
  parameter int unsigned V_DISP    = 480,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned FB_BASE   = 0
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              frame_start,
  input  logic              data_req,
  output logic [11:0]       pixel_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [11:0]       mem_rdata,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int unsigned XW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int unsigned LW = $clog2(V_DISP + 1);
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

`ifdef VGA_LINE_FETCH_UNDERFLOW_MARK_EN
  localparam logic [11:0] UfPix = 12'hF00;
`else
  localparam logic [11:0] UfPix = 12'h000;
`endif

  typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

  // Fetch side state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XW-1:0]     col_q, col_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [LW-1:0]     fetch_line_q, fetch_line_d;
  logic              restart_q, restart_d;

  // Display side state
  logic [1:0]        valid_q, valid_d;
  logic              disp_sel_q, disp_sel_d;
  logic [XW-1:0]     rd_x_q, rd_x_d;
  logic              data_req_q;
  logic [11:0]       pixel_q, pixel_d;
  logic              underflow_q, underflow_d;
  logic [15:0]       uf_cnt_q, uf_cnt_d;

  // Line storage, no reset: contents only matter once the valid flag is set
  logic [11:0]       buf0_q [H_DISP];
  logic [11:0]       buf1_q [H_DISP];

  // Combinational helpers
  logic              tgt;
  logic              pend;
  logic              fetch_go;
  logic              restart_now;
  logic              line_done;
  logic              wr_en;
  logic              dr_rise;
  logic              dr_fall;
  logic [11:0]       rd_word;

  // Frame-buffer word address of a given line and column, wrapped to ADDR_W
  function automatic logic [ADDR_W-1:0] word_addr(input logic [LW-1:0] line,
                                                  input logic [XW-1:0] col);
    return ADDR_W'(64'(FB_BASE) + 64'(line) * 64'(H_DISP) + 64'(col));
  endfunction

  assign mem_req       = (state_q == StReq);
  assign mem_addr      = mem_addr_q;
  assign pixel_data    = pixel_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = uf_cnt_q;

  // Even lines go to buffer 0 and odd lines to buffer 1. This matches the order
  // in which the display alternates between the buffers.
  assign tgt     = fetch_line_q[0];
  assign dr_rise = data_req & ~data_req_q;
  assign dr_fall = ~data_req & data_req_q;
  assign rd_word = disp_sel_q ? buf1_q[rd_x_q] : buf0_q[rd_x_q];

  // Do not refill the buffer that is on screen in the middle of a line.
  assign fetch_go = !valid_q[tgt] && (fetch_line_q < LW'(V_DISP)) &&
                    !((tgt == disp_sel_q) && data_req_q);

  // Fetch FSM next state, restart handling and buffer write enable
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    beat_d       = beat_q;
    fetch_line_d = fetch_line_q;
    mem_addr_d   = mem_addr_q;
    restart_d    = restart_q | frame_start;
    pend         = restart_q | frame_start;
    restart_now  = 1'b0;
    line_done    = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend) begin
          restart_now = 1'b1;
        end else if (fetch_go) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // A granted burst always runs to completion, and a pending restart waits for it.
        if (mem_ack) begin
          state_d = StBurst;
          beat_d  = '0;
        end else if (pend) begin
          restart_now = 1'b1;
          state_d     = StIdle;
        end
      end
      StBurst: begin
        if (mem_rvalid) begin
          wr_en  = 1'b1;
          col_d  = col_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BURST_LEN - 1)) begin
            if (pend) begin
              restart_now = 1'b1;
              state_d     = StIdle;
            end else if (col_q == XW'(H_DISP - 1)) begin
              line_done    = 1'b1;
              col_d        = '0;
              fetch_line_d = fetch_line_q + 1'b1;
              state_d      = StIdle;
            end else begin
              state_d = StReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (restart_now) begin
      restart_d    = 1'b0;
      fetch_line_d = '0;
      col_d        = '0;
    end

    // Capture the burst address on entry to REQ so it stays stable until the grant
    if ((state_d == StReq) && (state_q != StReq)) begin
      mem_addr_d = word_addr(fetch_line_d, col_d);
    end
  end

  // Display next state: pixel output, line-end swap, underflow tracking
  always_comb begin
    valid_d     = valid_q;
    disp_sel_d  = disp_sel_q;
    rd_x_d      = rd_x_q;
    pixel_d     = 12'h000;
    underflow_d = underflow_q;
    uf_cnt_d    = uf_cnt_q;

    if (data_req) begin
      pixel_d = valid_q[disp_sel_q] ? rd_word : UfPix;
      if (rd_x_q != XW'(H_DISP - 1)) begin
        rd_x_d = rd_x_q + 1'b1;
      end
    end

    if (dr_fall) begin
      valid_d[disp_sel_q] = 1'b0;
      disp_sel_d          = ~disp_sel_q;
      rd_x_d              = '0;
    end

    // The buffer being filled and the buffer on screen differ in normal
    // operation, so this set and the clear above never collide.
    if (line_done) begin
      valid_d[tgt] = 1'b1;
    end

    if (dr_rise && !valid_q[disp_sel_q]) begin
      underflow_d = 1'b1;
`ifdef VGA_LINE_FETCH_UNDERFLOW_MARK_EN
      if (uf_cnt_q != 16'hFFFF) begin
        uf_cnt_d = uf_cnt_q + 16'd1;
      end
`endif
    end

`ifndef VGA_LINE_FETCH_UNDERFLOW_MARK_EN
    uf_cnt_d = 16'd0;
`endif

    // A restart does not touch the underflow statistics.
    if (restart_now) begin
      valid_d    = 2'b00;
      disp_sel_d = 1'b0;
      rd_x_d     = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      col_q        <= '0;
      beat_q       <= '0;
      fetch_line_q <= '0;
      restart_q    <= 1'b0;
      valid_q      <= 2'b00;
      disp_sel_q   <= 1'b0;
      rd_x_q       <= '0;
      data_req_q   <= 1'b0;
      pixel_q      <= 12'h000;
      underflow_q  <= 1'b0;
      uf_cnt_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      col_q        <= col_d;
      beat_q       <= beat_d;
      fetch_line_q <= fetch_line_d;
      restart_q    <= restart_d;
      valid_q      <= valid_d;
      disp_sel_q   <= disp_sel_d;
      rd_x_q       <= rd_x_d;
      data_req_q   <= data_req;
      pixel_q      <= pixel_d;
      underflow_q  <= underflow_d;
      uf_cnt_q     <= uf_cnt_d;
    end
  end

  // Burst word write into the target buffer; a reset abandons the burst
  always_ff @(posedge vga_clk) begin
    if (wr_en && sys_rst_n) begin
      if (tgt) begin
        buf1_q[col_q] <= mem_rdata;
      end else begin
        buf0_q[col_q] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch (H_DISP=32, V_DISP=4, BURST_LEN=8, FB_BASE=100).
// A memory model acknowledges requests and returns rdata equal to the word address.
module tb_vga_line_fetch;

  localparam int unsigned HD = 32;
  localparam int unsigned VD = 4;
  localparam int unsigned BL = 8;
  localparam int unsigned FB = 100;

`ifdef VGA_LINE_FETCH_UNDERFLOW_MARK_EN
  localparam logic [11:0] UF_PIX  = 12'hF00;
  localparam logic [15:0] UF_CNT1 = 16'd1;
`else
  localparam logic [11:0] UF_PIX  = 12'h000;
  localparam logic [15:0] UF_CNT1 = 16'd0;
`endif

  typedef struct {
    logic [11:0] base;
    bit          uf_line;
    logic        exp_uf;
    logic [15:0] exp_cnt;
  } line_vec_t;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        frame_start;
  logic        data_req;
  logic [11:0] pixel_data;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [11:0] mem_rdata;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned addr_log[$];
  bit          sending = 1'b0;
  int          beat = 0;
  int unsigned base = 0;
  int          ack_limit = 0;

  vga_line_fetch #(
    .H_DISP   (HD),
    .V_DISP   (VD),
    .BURST_LEN(BL),
    .ADDR_W   (19),
    .FB_BASE  (FB)
  ) dut (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_start  (frame_start),
    .data_req     (data_req),
    .pixel_data   (pixel_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // Memory model: grants a request one cycle after it appears (up to ack_limit
  // grants in total), then streams BL words with rdata = address.
  initial begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 12'h000;
    forever begin
      @(posedge vga_clk);
      #1;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (sending) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 12'(base + beat);
        beat++;
        if (beat == BL) sending = 1'b0;
      end else if (mem_req && (addr_log.size() < ack_limit)) begin
        mem_ack = 1'b1;
        base    = 32'(mem_addr);
        addr_log.push_back(32'(mem_addr));
        sending = 1'b1;
        beat    = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  // Wait until at least target grants have been logged, optionally until the burst drains
  task automatic wait_acks(input string name, input int target, input bit need_idle);
    int t = 0;
    while (((addr_log.size() < target) || (need_idle && sending)) && (t < 600)) begin
      tick(1);
      t++;
    end
    check({name, "_wait"}, 32'(t < 600), 32'd1);
  endtask

  task automatic wait_beat(input string name, input int b);
    int t = 0;
    while (!(sending && (beat == b)) && (t < 600)) begin
      tick(1);
      t++;
    end
    check({name, "_wait"}, 32'(t < 600), 32'd1);
  endtask

  // One display line: HD cycles of data_req then 16 idle cycles
  task automatic show_line(input string tag, input logic [11:0] base_pix, input bit uf_line);
    for (int c = 0; c < int'(HD) + 16; c++) begin
      data_req = (c < int'(HD));
      tick(1);
      if (c < int'(HD)) begin
        check($sformatf("%s_pix%0d", tag, c), 32'(pixel_data),
              32'(uf_line ? UF_PIX : base_pix + 12'(c)));
      end else if (c == int'(HD)) begin
        check({tag, "_blank"}, 32'(pixel_data), 32'd0);
      end
    end
  endtask

  initial begin
    line_vec_t tab1 [4];
    line_vec_t tab2 [2];
    int        idx;

    tab1[0] = '{12'd100, 1'b0, 1'b0, 16'd0};
    tab1[1] = '{12'd132, 1'b0, 1'b0, 16'd0};
    tab1[2] = '{12'd164, 1'b0, 1'b0, 16'd0};
    tab1[3] = '{12'd196, 1'b0, 1'b0, 16'd0};
    tab2[0] = '{12'd100, 1'b0, 1'b0, 16'd0};
    tab2[1] = '{12'd132, 1'b1, 1'b1, UF_CNT1};

    sys_rst_n   = 1'b0;
    frame_start = 1'b0;
    data_req    = 1'b0;
    tick(3);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pixel", 32'(pixel_data), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);

    // Full frame: two lines prefetched, four lines displayed
    ack_limit   = 16;
    sys_rst_n   = 1'b1;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_acks("t1_fill", 8, 1'b1);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_addr%0d", i), addr_log[i], 32'(FB + BL * i));
    end
    for (int i = 0; i < 4; i++) begin
      show_line($sformatf("t1_l%0d", i), tab1[i].base, tab1[i].uf_line);
      check($sformatf("t1_l%0d_uf", i), 32'(underflow), 32'(tab1[i].exp_uf));
      check($sformatf("t1_l%0d_cnt", i), 32'(underflow_cnt), 32'(tab1[i].exp_cnt));
    end
    tick(20);
    check("t1_nbursts", 32'(addr_log.size()), 32'd16);
    for (int i = 8; i < 16; i++) begin
      check($sformatf("t1_addr%0d", i), addr_log[i], 32'(FB + BL * i));
    end
    check("t1_no_fetch_past_end", 32'(mem_req), 32'd0);

    // Underflow: line 1 grant withheld across its display
    idx         = addr_log.size();
    ack_limit   = idx + 4;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_acks("t2_fill", idx + 4, 1'b1);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), addr_log[idx + i], 32'(FB + BL * i));
    end
    check("t2_req_pending", 32'(mem_req), 32'd1);
    check("t2_req_addr", 32'(mem_addr), 32'd132);
    for (int i = 0; i < 2; i++) begin
      show_line($sformatf("t2_l%0d", i), tab2[i].base, tab2[i].uf_line);
      check($sformatf("t2_l%0d_uf", i), 32'(underflow), 32'(tab2[i].exp_uf));
      check($sformatf("t2_l%0d_cnt", i), 32'(underflow_cnt), 32'(tab2[i].exp_cnt));
    end
    check("t2_req_held", 32'(mem_req), 32'd1);
    check("t2_addr_held", 32'(mem_addr), 32'd132);

    // Restart while a request is waiting for its grant
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("t2b_req_drop", 32'(mem_req), 32'd0);
    tick(1);
    check("t2b_req_again", 32'(mem_req), 32'd1);
    check("t2b_addr_restart", 32'(mem_addr), 32'd100);
    check("t2b_uf_kept", 32'(underflow), 32'd1);

    // Restart during a burst: burst completes, then refetch from line 0
    idx       = addr_log.size();
    ack_limit = idx + 2;
    wait_beat("t3_beat", 3);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_acks("t3_reack", idx + 2, 1'b0);
    check("t3_addr_first", addr_log[idx], 32'd100);
    check("t3_addr_after_restart", addr_log[idx + 1], 32'd100);
    check("t3_uf_kept", 32'(underflow), 32'd1);
    check("t3_cnt_kept", 32'(underflow_cnt), 32'(UF_CNT1));

    // Reset during a burst: stray words ignored, clean refetch afterwards
    wait_beat("t4_beat", 2);
    ack_limit = addr_log.size();
    sys_rst_n = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    check("t4_mem_req", 32'(mem_req), 32'd0);
    check("t4_pixel", 32'(pixel_data), 32'd0);
    check("t4_mem_addr", 32'(mem_addr), 32'd0);
    check("t4_underflow", 32'(underflow), 32'd0);
    check("t4_uf_cnt", 32'(underflow_cnt), 32'd0);
    tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    idx       = addr_log.size();
    ack_limit = idx + 4;
    wait_acks("t4_fill", idx + 4, 1'b1);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_addr%0d", i), addr_log[idx + i], 32'(FB + BL * i));
    end
    show_line("t4_l0", 12'd100, 1'b0);
    check("t4_l0_uf", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
